// File: rtl/knn_drv_master_if.sv
// knn_drv_master_if: native register-bus connection between the KNN driver
// (initiator) and the KNN accelerator's slave register port.
interface knn_drv_master_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic                  m_valid;
   logic [ADDR_W-1:0]     m_addr;
   logic [DATA_W-1:0]     m_wdata;
   logic [DATA_W/8-1:0]   m_wstrb;
   logic [DATA_W-1:0]     m_rdata;
   logic                  m_ready;

   modport master (
      output m_valid, m_addr, m_wdata, m_wstrb,
      input  m_rdata, m_ready
   );

   modport slave (
      input  m_valid, m_addr, m_wdata, m_wstrb,
      output m_rdata, m_ready
   );
endinterface

// File: rtl/knn_drv_master.sv
// knn_drv_master: feeds a training set from a point stream into the KNN
// accelerator over its native register bus, then reads back the
// neighbour-info registers and emits them as result strobes.
module knn_drv_master #(
   parameter int  ADDR_W      = 8,
   parameter int  DATA_W      = 32,
   parameter int  LABEL_W     = 8,
   parameter int  N_NEIGH     = 10,
   parameter int  ADDR_RESET  = 0,
   parameter int  ADDR_ENABLE = 1,
   parameter int  ADDR_A      = 2,
   parameter int  ADDR_B      = 3,
   parameter int  ADDR_LABEL  = 4,
   parameter int  ADDR_INFO0  = 5,
   localparam int IDX_W       = (N_NEIGH > 1) ? $clog2(N_NEIGH) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_start,
   input  logic [15:0]         n_points,
   input  logic                pt_valid,
   output logic                pt_ready,
   input  logic [DATA_W-1:0]   pt_a,
   input  logic [DATA_W-1:0]   pt_b,
   input  logic [LABEL_W-1:0]  pt_label,
   knn_drv_master_if.master    bus,
   output logic                res_valid,
   output logic [IDX_W-1:0]    res_idx,
   output logic [LABEL_W-1:0]  res_data,
   output logic                busy,
   output logic                done
);

   typedef enum logic [3:0] {
      S_IDLE, S_RST1, S_RST0, S_PT_WAIT, S_WR_A, S_WR_B, S_WR_LBL,
      S_EN1, S_EN0, S_RD_INFO, S_DONE
   } state_t;

   state_t               state, state_nx;
   logic                 gap, gap_nx;
   logic [15:0]          cnt;
   logic [IDX_W-1:0]     idx;
   logic [DATA_W-1:0]    a_q, b_q;
   logic [LABEL_W-1:0]   lbl_q;
   logic                 is_bus, mv, fire, last_idx;
   logic [ADDR_W-1:0]    addr;
   logic [DATA_W-1:0]    wdata;
   logic [DATA_W/8-1:0]  wstrb;
   logic                 unused_rdata;

   // The upper read-data bits carry nothing the driver needs.
   assign unused_rdata = ^bus.m_rdata;

   // Each bus state owns one transaction: request until ready, then a
   // one-cycle GAP (gap=1) spent in the same state before moving on.
   assign is_bus   = state inside {S_RST1, S_RST0, S_WR_A, S_WR_B, S_WR_LBL,
                                   S_EN1, S_EN0, S_RD_INFO};
   assign mv       = is_bus && !gap;
   assign fire     = mv && bus.m_ready;
   assign last_idx = (idx == IDX_W'(N_NEIGH - 1));

   assign pt_ready  = (state == S_PT_WAIT) && (cnt != '0);
   assign busy      = (state != S_IDLE) && (state != S_DONE);
   assign done      = (state == S_DONE);
   assign res_valid = (state == S_RD_INFO) && fire;
   assign res_idx   = res_valid ? idx : '0;
   assign res_data  = res_valid ? bus.m_rdata[LABEL_W-1:0] : '0;

   assign bus.m_valid = mv;
   assign bus.m_addr  = addr;
   assign bus.m_wdata = wdata;
   assign bus.m_wstrb = wstrb;

   // FSM state register; async reset drops m_valid immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         gap   <= 1'b0;
      end else begin
         state <= state_nx;
         gap   <= gap_nx;
      end
   end

   // Next-state logic, including the GAP sub-phase of every bus state.
   always_comb begin
      state_nx = state;
      gap_nx   = gap;
      case (state)
         S_IDLE:    if (cmd_start) state_nx = S_RST1;
         S_PT_WAIT: begin
            if (cnt == '0)    state_nx = S_RD_INFO;
            else if (pt_valid) state_nx = S_WR_A;
         end
         S_DONE:    state_nx = S_IDLE;
         default: begin
            if (fire) begin
               gap_nx = 1'b1;
            end else if (gap) begin
               gap_nx = 1'b0;
               case (state)
                  S_RST1:    state_nx = S_RST0;
                  S_RST0:    state_nx = S_PT_WAIT;
                  S_WR_A:    state_nx = S_WR_B;
                  S_WR_B:    state_nx = S_WR_LBL;
                  S_WR_LBL:  state_nx = S_EN1;
                  S_EN1:     state_nx = S_EN0;
                  S_EN0:     state_nx = S_PT_WAIT;
                  S_RD_INFO: state_nx = last_idx ? S_DONE : S_RD_INFO;
                  default:   state_nx = S_IDLE;
               endcase
            end
         end
      endcase
   end

   // Bus request fields; zero whenever no request is outstanding.
   always_comb begin
      addr  = '0;
      wdata = '0;
      wstrb = '0;
      if (mv) begin
         wstrb = '1;
         case (state)
            S_RST1:    begin addr = ADDR_W'(ADDR_RESET);  wdata = DATA_W'(1); end
            S_RST0:    addr = ADDR_W'(ADDR_RESET);
            S_WR_A:    begin addr = ADDR_W'(ADDR_A);      wdata = a_q; end
            S_WR_B:    begin addr = ADDR_W'(ADDR_B);      wdata = b_q; end
            S_WR_LBL:  begin addr = ADDR_W'(ADDR_LABEL);  wdata = DATA_W'(lbl_q); end
            S_EN1:     begin addr = ADDR_W'(ADDR_ENABLE); wdata = DATA_W'(1); end
            S_EN0:     addr = ADDR_W'(ADDR_ENABLE);
            S_RD_INFO: begin
               addr  = ADDR_W'(ADDR_INFO0) + ADDR_W'(idx);
               wstrb = '0;
            end
            default:   wstrb = '0;
         endcase
      end
   end

   // Point counter, INFO index and captured point registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         idx   <= '0;
         a_q   <= '0;
         b_q   <= '0;
         lbl_q <= '0;
      end else begin
         if (state == S_IDLE && cmd_start) begin
            cnt <= n_points;
            idx <= '0;
         end
         if (pt_valid && pt_ready) begin
            a_q   <= pt_a;
            b_q   <= pt_b;
            lbl_q <= pt_label;
         end
         if (state == S_EN0 && fire) cnt <= cnt - 16'd1;
         if (state == S_RD_INFO && gap && !last_idx) idx <= idx + IDX_W'(1);
      end
   end

endmodule
